// File: rtl/video_vsync_ctrl.sv
// video_vsync_ctrl: vsync interrupt, frame counter and tear-free page-flip
// controller on the mem_clk register domain.
// Optional feature macro: VIDEO_FRAME_COUNTER_EN (implements FRAME_COUNT;
// without it, word index 0x2 reads 0).
module video_vsync_ctrl (
  input  logic        mem_clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_we,
  input  logic [11:0] mem_addr,
  input  logic [31:0] mem_write,
  output logic [31:0] mem_read,
  input  logic        vsync_in,
  input  logic        vsync_pol,
  input  logic        enable_in,
  output logic [63:0] base_out,
  output logic        base_valid,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_COMMIT = 2'd2
  } flip_state_t;

  flip_state_t state_r, state_nxt_s;

  logic        sync1_r, sync2_r, prev_r, vs_edge_r;
  logic [2:0]  status_r, status_nxt_s;
  logic [2:0]  irq_en_r;
  logic [63:0] staging_r, staging_nxt_s;
  logic [31:0] rd_data_s;
  logic        commit_go_s;
  logic [9:0]  word_idx_s;
  logic        wr_en_s;
  logic        unused_addr_bits;

`ifdef VIDEO_FRAME_COUNTER_EN
  logic [31:0] frame_count_r;
`endif

  assign word_idx_s       = mem_addr[11:2];
  assign wr_en_s          = mem_en && (mem_we == 4'hF);
  assign unused_addr_bits = ^mem_addr[1:0];

  // Two-flop synchroniser, history flop and registered leading-edge detect.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      prev_r    <= 1'b0;
      vs_edge_r <= 1'b0;
    end else begin
      sync1_r   <= vsync_in;
      sync2_r   <= sync1_r;
      prev_r    <= sync2_r;
      vs_edge_r <= (sync2_r ^ vsync_pol) & ~(prev_r ^ vsync_pol) & enable_in;
    end
  end

  // Flip FSM next state; cancel takes priority over a pending commit.
  always_comb begin
    state_nxt_s = state_r;
    commit_go_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (wr_en_s && (word_idx_s == 10'h005) && mem_write[0]) begin
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (wr_en_s && (word_idx_s == 10'h005) && !mem_write[0]) begin
          state_nxt_s = ST_IDLE;
        end else if (vs_edge_r || !enable_in) begin
          state_nxt_s = ST_COMMIT;
          commit_go_s = 1'b1;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_COMMIT: begin
        // A new request landing in the commit cycle is not dropped.
        if (wr_en_s && (word_idx_s == 10'h005) && mem_write[0]) begin
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Staging base update; the committed base sees a same-cycle staging write.
  always_comb begin
    staging_nxt_s = staging_r;
    if (wr_en_s && (word_idx_s == 10'h003)) begin
      staging_nxt_s[31:0] = mem_write;
    end else begin
      staging_nxt_s[31:0] = staging_r[31:0];
    end
    if (wr_en_s && (word_idx_s == 10'h004)) begin
      staging_nxt_s[63:32] = mem_write;
    end else begin
      staging_nxt_s[63:32] = staging_r[63:32];
    end
  end

  // STATUS next value: W1C first, hardware sets afterwards so set wins.
  always_comb begin
    status_nxt_s = status_r;
    if (wr_en_s && (word_idx_s == 10'h000)) begin
      status_nxt_s = status_r & ~mem_write[2:0];
    end else begin
      status_nxt_s = status_r;
    end
    if (vs_edge_r) begin
      status_nxt_s[0] = 1'b1;
      if (status_r[0]) begin
        status_nxt_s[2] = 1'b1;
      end else begin
        status_nxt_s[2] = status_nxt_s[2];
      end
    end else begin
      status_nxt_s[0] = status_nxt_s[0];
    end
    if (commit_go_s) begin
      status_nxt_s[1] = 1'b1;
    end else begin
      status_nxt_s[1] = status_nxt_s[1];
    end
  end

  // Read mux over the current (pre-write) register values.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (word_idx_s)
      10'h000: rd_data_s = {29'd0, status_r};
      10'h001: rd_data_s = {29'd0, irq_en_r};
`ifdef VIDEO_FRAME_COUNTER_EN
      10'h002: rd_data_s = frame_count_r;
`endif
      10'h003: rd_data_s = staging_r[31:0];
      10'h004: rd_data_s = staging_r[63:32];
      10'h005: rd_data_s = {31'd0, (state_r == ST_ARMED)};
      default: rd_data_s = 32'h0000_0000;
    endcase
  end

  // Control/status registers, flip outputs, interrupt and read data.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      status_r   <= 3'b000;
      irq_en_r   <= 3'b000;
      staging_r  <= 64'd0;
      base_out   <= 64'd0;
      base_valid <= 1'b0;
      irq        <= 1'b0;
      mem_read   <= 32'h0000_0000;
    end else begin
      state_r    <= state_nxt_s;
      status_r   <= status_nxt_s;
      staging_r  <= staging_nxt_s;
      base_valid <= commit_go_s;
      irq        <= |(status_r & irq_en_r);
      if (wr_en_s && (word_idx_s == 10'h001)) begin
        irq_en_r <= mem_write[2:0];
      end
      if (commit_go_s) begin
        base_out <= {staging_nxt_s[63:3], 3'b000};
      end
      if (mem_en) begin
        mem_read <= rd_data_s;
      end
    end
  end

`ifdef VIDEO_FRAME_COUNTER_EN
  // Frame counter, one increment per detected vsync leading edge.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      frame_count_r <= 32'd0;
    end else if (vs_edge_r) begin
      frame_count_r <= frame_count_r + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_vsync_ctrl.sv
// Self-checking bench for video_vsync_ctrl with a transaction-level model.
module tb_video_vsync_ctrl;

  logic        mem_clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en = 1'b0;
  logic [3:0]  mem_we = 4'h0;
  logic [11:0] mem_addr = 12'h000;
  logic [31:0] mem_write = 32'h0;
  logic [31:0] mem_read;
  logic        vsync_in = 1'b1;
  logic        vsync_pol = 1'b1;
  logic        enable_in = 1'b1;
  logic [63:0] base_out;
  logic        base_valid;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  int bv_count = 0;

  // Transaction-level model state.
  logic [2:0]  m_status = 3'b000;
  logic [2:0]  m_irq_en = 3'b000;
  logic [31:0] m_fc = 32'd0;
  logic [63:0] m_stage = 64'd0;
  logic [63:0] m_base = 64'd0;
  bit          m_armed = 1'b0;

  video_vsync_ctrl dut (
    .mem_clk(mem_clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
    .vsync_in(vsync_in), .vsync_pol(vsync_pol), .enable_in(enable_in),
    .base_out(base_out), .base_valid(base_valid), .irq(irq)
  );

  always #5 mem_clk = ~mem_clk;

  // Count base_valid pulses away from the active edge.
  always @(negedge mem_clk) begin
    if (base_valid === 1'b1) bv_count = bv_count + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_fc();
`ifdef VIDEO_FRAME_COUNTER_EN
    return m_fc;
`else
    return 32'd0;
`endif
  endfunction

  task automatic commit_model();
    m_armed = 1'b0;
    m_base = {m_stage[63:3], 3'b000};
    m_status[1] = 1'b1;
  endtask

  task automatic bus_write(input logic [9:0] idx, input logic [31:0] data, input logic [3:0] we);
    mem_en = 1'b1; mem_we = we; mem_addr = {idx, 2'b00}; mem_write = data;
    @(posedge mem_clk);
    @(negedge mem_clk);
    mem_en = 1'b0; mem_we = 4'h0;
  endtask

  task automatic bus_read(input logic [9:0] idx, output logic [31:0] data);
    mem_en = 1'b1; mem_we = 4'h0; mem_addr = {idx, 2'b00};
    @(posedge mem_clk);
    @(negedge mem_clk);
    data = mem_read;
    mem_en = 1'b0;
  endtask

  task automatic write_stage(input logic [63:0] v);
    bus_write(10'h003, v[31:0], 4'hF);
    bus_write(10'h004, v[63:32], 4'hF);
    m_stage = v;
  endtask

  task automatic arm_flip();
    bus_write(10'h005, 32'h1, 4'hF);
    m_armed = 1'b1;
    if (!enable_in) commit_model();
  endtask

  task automatic w1c(input logic [2:0] mask);
    bus_write(10'h000, {29'd0, mask}, 4'hF);
    m_status = m_status & ~mask;
  endtask

  task automatic set_irq_en(input logic [2:0] v);
    bus_write(10'h001, {29'd0, v}, 4'hF);
    m_irq_en = v;
  endtask

  task automatic vsync_pulse(input int len);
    vsync_in = ~vsync_pol;
    repeat (len) @(negedge mem_clk);
    vsync_in = vsync_pol;
    repeat (8) @(negedge mem_clk);
    if (enable_in) begin
      m_fc = m_fc + 32'd1;
      if (m_status[0]) m_status[2] = 1'b1;
      m_status[0] = 1'b1;
      if (m_armed) commit_model();
    end
  endtask

  task automatic verify_all(input string tag);
    logic [31:0] rd;
    repeat (3) @(negedge mem_clk);
    bus_read(10'h000, rd); check_val({tag, "_status"}, rd, {29'd0, m_status});
    bus_read(10'h002, rd); check_val({tag, "_fcount"}, rd, exp_fc());
    bus_read(10'h005, rd); check_val({tag, "_armed"}, rd, {31'd0, m_armed});
    bus_read(10'h001, rd); check_val({tag, "_irqen"}, rd, {29'd0, m_irq_en});
    check_val({tag, "_irq"}, irq, |(m_status & m_irq_en));
    check_val({tag, "_base"}, base_out, m_base);
  endtask

  initial begin
    logic [31:0] rd, held;
    logic [63:0] v;
    int bv0, exp_bv, np;

    // Reset state.
    repeat (3) @(negedge mem_clk);
    check_val("rst_mem_read", mem_read, 32'h0);
    check_val("rst_base_out", base_out, 64'd0);
    check_val("rst_base_valid", base_valid, 1'b0);
    check_val("rst_irq", irq, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge mem_clk);
    bus_read(10'h001, rd); check_val("rst_irq_en", rd, 32'h0);
    bus_read(10'h005, rd); check_val("rst_flip_ctrl", rd, 32'h0);

    // Three active-low vsync pulses: count 3, VS and OVR set.
    for (int i = 0; i < 3; i++) vsync_pulse(10);
    bus_read(10'h002, rd);
`ifdef VIDEO_FRAME_COUNTER_EN
    check_val("dir_fcount", rd, 32'd3);
`else
    check_val("dir_fcount_absent", rd, 32'd0);
`endif
    bus_read(10'h000, rd); check_val("dir_status", rd, 32'h5);
    set_irq_en(3'b001);
    repeat (2) @(negedge mem_clk);
    check_val("dir_irq_on", irq, 1'b1);
    w1c(3'b101);
    check_val("dir_irq_hold", irq, 1'b1);
    @(negedge mem_clk);
    check_val("dir_irq_off", irq, 1'b0);
    verify_all("dir1");

    // Flip on the next vsync.
    write_stage(64'h0000_0001_1000_0007);
    bus_write(10'h005, 32'h1, 4'hF); m_armed = 1'b1;
    bus_read(10'h005, rd); check_val("flip_armed", rd, 32'h1);
    bv0 = bv_count;
    vsync_pulse(6);
    check_val("flip_base", base_out, 64'h0000_0001_1000_0000);
    check_val("flip_bv_pulses", bv_count - bv0, 1);
    verify_all("flip1");
    w1c(3'b111);

    // Flip with display disabled: commits without vsync.
    enable_in = 1'b0;
    write_stage({$urandom, $urandom});
    arm_flip();
    check_val("dis_bv_early", base_valid, 1'b0);
    @(negedge mem_clk);
    check_val("dis_bv", base_valid, 1'b1);
    check_val("dis_base", base_out, m_base);
    @(negedge mem_clk);
    check_val("dis_bv_single", base_valid, 1'b0);
    enable_in = 1'b1;
    verify_all("dis");
    w1c(3'b111);

    // Cancel: no commit, no FD.
    write_stage(64'hDEAD_BEEF_0000_0010);
    bus_write(10'h005, 32'h1, 4'hF); m_armed = 1'b1;
    bus_write(10'h005, 32'h0, 4'hF); m_armed = 1'b0;
    bv0 = bv_count;
    vsync_pulse(5);
    check_val("cancel_bv", bv_count - bv0, 0);
    verify_all("cancel");
    w1c(3'b111);

    // W1C of VS in the exact cycle the edge fires: set wins.
    vsync_in = ~vsync_pol;
    repeat (3) @(negedge mem_clk);
    bus_write(10'h000, 32'h1, 4'hF);
    m_fc = m_fc + 32'd1; m_status[0] = 1'b1;
    vsync_in = vsync_pol;
    repeat (8) @(negedge mem_clk);
    bus_read(10'h000, rd); check_val("w1c_race_vs", rd, 32'h1);
    verify_all("race");

    // Register-map corner cases.
    bus_write(10'h001, 32'h7, 4'h3);
    bus_write(10'h006, 32'hFFFF_FFFF, 4'hF);
    bus_read(10'h006, rd); check_val("unmapped_read", rd, 32'h0);
    bus_read(10'h001, held); check_val("partial_we_ignored", held, {29'd0, m_irq_en});
    mem_addr = 12'h008;
    @(negedge mem_clk);
    check_val("read_hold", mem_read, held);

    // Randomised scenarios against the model.
    for (int it = 0; it < 20; it++) begin
      vsync_pol = 1'($urandom_range(1, 0));
      vsync_in = vsync_pol;
      repeat (6) @(negedge mem_clk);
      enable_in = ($urandom_range(3, 0) != 0);
      repeat (2) @(negedge mem_clk);
      set_irq_en(3'($urandom_range(7, 0)));
      bv0 = bv_count;
      exp_bv = 0;
      if ($urandom_range(1, 0) == 1) begin
        v = {$urandom, $urandom};
        write_stage(v);
        arm_flip();
        if (!enable_in) exp_bv = 1;
      end
      np = $urandom_range(3, 0);
      for (int p = 0; p < np; p++) begin
        if (m_armed && enable_in) exp_bv = 1;
        vsync_pulse($urandom_range(10, 3));
      end
      if (m_armed) begin
        bus_read(10'h005, rd); check_val("rnd_still_armed", rd, 32'h1);
        bus_write(10'h005, 32'h0, 4'hF); m_armed = 1'b0;
      end
      repeat (3) @(negedge mem_clk);
      check_val("rnd_bv_pulses", bv_count - bv0, exp_bv);
      verify_all("rnd");
      w1c(3'($urandom_range(7, 0)));
      verify_all("rnd_clr");
    end

`ifdef VIDEO_FRAME_COUNTER_EN
    // Counter wrap.
    enable_in = 1'b1;
    force dut.frame_count_r = 32'hFFFF_FFFF;
    @(negedge mem_clk);
    release dut.frame_count_r;
    m_fc = 32'hFFFF_FFFF;
    vsync_pulse(5);
    bus_read(10'h002, rd); check_val("fcount_wrap", rd, 32'h0);
`else
    bus_read(10'h002, rd); check_val("fcount_absent_end", rd, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/video_vsync_ctrl.md
# video_vsync_ctrl

Vsync interrupt and page-flip controller on the register clock domain of the display controller. It synchronises the pixel-domain vsync output of the video unit into mem_clk and counts frames. It raises a level interrupt on vsync and flip completion, and performs tear-free framebuffer base flips. The new base is handed to the video unit's base register at the vsync leading edge. Register access uses the same BRAM-style port as the other control blocks, driven by a NASTI-lite BRAM controller.

## Interface
- No parameters; register word index is mem_addr[11:2].
- mem_clk  in  1  register/system clock
- rst  in  1  asynchronous, active-high reset
- mem_en  in  1  access strobe
- mem_we  in  4  byte write enables; a write occurs only when all four are set
- mem_addr  in  12  byte address
- mem_write  in  32  write data
- mem_read  out  32  registered read data
- vsync_in  in  1  raw vsync from pixel domain (asynchronous)
- vsync_pol  in  1  0 = active-high vsync, 1 = active-low (mem_clk domain)
- enable_in  in  1  display enable (mem_clk domain)
- base_out  out  64  framebuffer base to video unit, bits [2:0] forced 0
- base_valid  out  1  one-cycle strobe when base_out changes
- irq  out  1  level interrupt, registered

## Operation
- Registers, by word index:
  - 0x0 STATUS (W1C):
    - bit0 VS: vsync seen
    - bit1 FD: flip done
    - bit2 OVR: VS edge while VS already pending
  - 0x1 IRQ_EN: bits[2:0], R/W.
  - 0x2 FRAME_COUNT: 32-bit, RO, wraps 0xFFFFFFFF→0.
  - 0x3 FLIP_LO: staging base [31:0]; 0x4 FLIP_HI: staging base [63:32]. Both R/W, usable any time.
  - 0x5 FLIP_CTRL: writing bit0=1 requests a flip; reads bit0 = ARMED.
  - Other indices read 0; writes to them are ignored.
- Vsync path:
  - vsync_in passes through 2 flops (s1, s2), then a history flop (prev).
  - active = s2 ^ vsync_pol.
  - edge = active & !(prev ^ vsync_pol) & enable_in.
  - prev always tracks s2; edges are masked while enable_in = 0.
- On edge: FRAME_COUNT += 1, VS set; OVR is also set if VS was already 1.
- Flip FSM:
  - IDLE → ARMED on a FLIP_CTRL write with bit0=1.
  - ARMED → COMMIT on edge, or on the next cycle if enable_in = 0.
  - COMMIT (1 cycle): base_out ← {staging[63:3], 3'b0}, base_valid = 1, FD set → IDLE.
  - A FLIP_CTRL write while ARMED keeps it ARMED (no-op).
  - Staging written while ARMED: the latest value is committed.
  - Writing bit0=0 while ARMED cancels: → IDLE, no FD.
- Simultaneous W1C clear and hardware set of the same bit: set wins.
- irq ← |(STATUS & IRQ_EN), registered each cycle.

## Timing
- Reset values: mem_read=0, base_out=0, base_valid=0, irq=0, STATUS=0, IRQ_EN=0, FRAME_COUNT=0, staging=0, FSM=IDLE, s1=s2=prev=0.
- Read latency: 1 cycle; mem_read updates only when mem_en=1, otherwise holds.
- A read returns the pre-write value of a register written in the same cycle.
- vsync_in becoming active (setup met at edge N): edge is high during cycle N+2→N+3; FRAME_COUNT/VS are visible at edge N+3; irq at N+4.
- Flip:
  - base_valid is asserted the cycle after the edge cycle.
  - FD is visible together with base_valid; irq rises one cycle later.
- Clearing via W1C at edge M: STATUS bit is 0 at M+1 unless re-set; irq falls at M+2.
- Reset mid-flip: FSM returns to IDLE and base_out returns to 0. No base_valid pulse is generated.

## Configuration
- VIDEO_FRAME_COUNTER_EN defined: FRAME_COUNT is implemented as above.
- Undefined: counter logic is absent and index 0x2 reads 0. VS/OVR/flip behaviour is unchanged.

## Test plan
- Reset: all outputs 0; read 0x1 → 0; read 0x5 → 0.
- vsync_pol=1, enable_in=1, vsync_in pulsed low for 10 cycles, three times:
  - FRAME_COUNT=3 and STATUS=0x5 (VS, OVR).
  - With IRQ_EN=1, irq=1; W1C 0x5 → irq=0 two cycles later.
- Write FLIP_LO=0x1000_0007, FLIP_HI=0x1, FLIP_CTRL=1:
  - read 0x5 → 1.
  - On the next vsync: base_out=0x1_1000_0000, one base_valid pulse, FD set, read 0x5 → 0.
- Flip with enable_in=0: base_valid appears 2 cycles after the FLIP_CTRL write; no vsync is required.
- W1C of VS issued in the exact cycle an edge occurs: VS remains 1.
- FRAME_COUNT preloaded through force to 0xFFFFFFFF, one vsync → reads 0.
  - With the macro undefined, read 0x2 → 0.
